mem_stage_unit: RTL and testbench
=================================

Name: mem_stage_unit

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs (WB_en, MEM_r_en, MEM_w_en, dest, alu_res, val_rm).
- Performs load/store to a word-addressed data memory with configurable wait states.
- Asserts freeze to hold the upstream pipeline while an access is in progress.
- Registers the results as the MEM/WB pipeline register feeding write-back.

Parameters:
- DEPTH, 64, data memory words (power of 2).
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 2, extra cycles per load/store (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- WB_en_in  in  1  write-back enable from EXE/MEM register
- MEM_r_en_in  in  1  load request
- MEM_w_en_in  in  1  store request
- dest_in  in  4  destination register
- alu_res_in  in  32  byte address (mem ops) or ALU result
- val_rm_in  in  32  store data
- freeze  out  1  combinational; high means upstream must hold its outputs stable
- WB_en_out  out  1  registered write-back enable
- MEM_r_en_out  out  1  registered; selects mem_data_out in WB mux
- dest_out  out  4  registered
- alu_res_out  out  32  registered
- mem_data_out  out  32  registered load data
- mem_err_out  out  1  registered error flag; tied 0 unless ADDR_CHECK_EN

Behaviour:
- Synchronous active-high reset, single clock.
- mem_req = MEM_r_en_in | MEM_w_en_in.
- Word index = (alu_res_in - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits. Out-of-range addresses wrap modulo DEPTH; the low 2 address bits are ignored.
- FSM states: IDLE, BUSY. Wait counter cnt is 4 bits.
- IDLE, no mem_req: freeze=0. Output register loads the inputs next edge; 1-cycle latency; mem_data_out holds.
- IDLE, mem_req, WAIT_CYCLES=0: access completes at the next edge and freeze never asserts.
  - Store writes val_rm_in at that edge.
  - Load latches mem[index] into mem_data_out.
- IDLE, mem_req, WAIT_CYCLES>0: freeze=1; next edge goes to BUSY with cnt=0. Output register loads a bubble: WB_en_out=0, MEM_r_en_out=0; other fields hold.
- BUSY, cnt<WAIT_CYCLES-1: freeze=1, cnt increments, bubble loaded.
- BUSY, cnt==WAIT_CYCLES-1: freeze=0 and the access completes at this edge (as above). Output register loads the inputs; next state IDLE.
- Timing: a mem op occupies WAIT_CYCLES+1 cycles; freeze is high for exactly WAIT_CYCLES cycles.
- Inputs are sampled only on the completing edge; upstream holds them stable while freeze=1.
- MEM_r_en_in and MEM_w_en_in both high: treated as a load, write suppressed.
- Store: WB_en_in is expected low and is passed through unchanged.
- Reset, including mid-access:
  - State returns to IDLE, cnt=0, freeze=0.
  - All outputs clear to 0.
  - Memory contents are not cleared, and an in-flight store is dropped.
- Data memory: synchronous write, asynchronous read, not reset.

Optional Feature:
- Macro: ADDR_CHECK_EN.
- Defined: an access is flagged when any of these holds:
  - alu_res_in < BASE_ADDR;
  - (alu_res_in - BASE_ADDR) >> 2 >= DEPTH;
  - alu_res_in[1:0] != 0.
- A flagged access still runs the full wait sequence. On the completing edge the store is suppressed, mem_data_out loads 0, and mem_err_out=1 for one cycle.
- Not defined: addresses wrap as described in Behaviour, and mem_err_out is constant 0.

Decomposition:
- Shared package arm_pkg holds:
  - constants: WORD_W=32, REG_IDX_W=4, default MEM_BASE_ADDR=1024;
  - typedef for FSM state enum {IDLE, BUSY}.
- One natural sub-module, data_mem (DEPTH x 32, sync write port, async read port).
- FSM, counter and output register stay in mem_stage_unit.

Test Plan:
- ALU op, WAIT_CYCLES=2: WB_en_in=1, dest_in=5, alu_res_in=0x2A -> freeze stays 0; next cycle WB_en_out=1, dest_out=5, alu_res_out=0x2A.
- Store then load, WAIT_CYCLES=2:
  - Store alu_res_in=1032, val_rm_in=0xDEADBEEF -> freeze high 2 cycles, then low.
  - Load from 1032 -> freeze high 2 cycles; then mem_data_out=0xDEADBEEF, MEM_r_en_out=1, WB_en_out=1.
  - WB_en_out=0 on every bubble cycle.
- WAIT_CYCLES=0: back-to-back stores to 1024/1028, then loads -> freeze never asserts; loads return the stored values 1 cycle later.
- Wrap: DEPTH=64, store 0x11 at 1024+256 -> load from 1024 returns 0x11 (without ADDR_CHECK_EN).
- Reset mid-access: assert rst in the 2nd freeze cycle of a store to 1036 -> next cycle freeze=0 and all outputs are 0; a later load from 1036 returns the prior contents.
- ADDR_CHECK_EN: store to 1025 -> write suppressed and mem_err_out=1 for exactly one cycle after the completing edge; load from 1020 -> mem_data_out=0, mem_err_out=1.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared constants and types for the ARM pipeline slice.
package arm_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned REG_IDX_W     = 4;
    localparam int unsigned MEM_BASE_ADDR = 1024;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module data_mem
    import arm_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: load/store with wait states, upstream freeze, MEM/WB register.
// Optional macro ADDR_CHECK_EN flags misaligned or out-of-range accesses.
module mem_stage_unit
    import arm_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 WB_en_in,
    input  logic                 MEM_r_en_in,
    input  logic                 MEM_w_en_in,
    input  logic [REG_IDX_W-1:0] dest_in,
    input  logic [WORD_W-1:0]    alu_res_in,
    input  logic [WORD_W-1:0]    val_rm_in,
    output logic                 freeze,
    output logic                 WB_en_out,
    output logic                 MEM_r_en_out,
    output logic [REG_IDX_W-1:0] dest_out,
    output logic [WORD_W-1:0]    alu_res_out,
    output logic [WORD_W-1:0]    mem_data_out,
    output logic                 mem_err_out
);

    localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]     LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [WORD_W-1:0] BASE  = WORD_W'(BASE_ADDR);

    state_t            state;
    logic [3:0]        cnt;
    logic              mem_req;
    logic              complete;
    logic              addr_err;
    logic              mem_we;
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] rdata;

    assign mem_req  = MEM_r_en_in | MEM_w_en_in;
    assign word_idx = AW'((alu_res_in - BASE) >> 2);

`ifdef ADDR_CHECK_EN
    logic [WORD_W-1:0] offset;
    assign offset   = alu_res_in - BASE;
    assign addr_err = mem_req && ((alu_res_in < BASE) || ((offset >> 2) >= WORD_W'(DEPTH)) ||
                                  (alu_res_in[1:0] != 2'b00));
`else
    assign addr_err = 1'b0;
`endif

    // The access completes on the edge where freeze drops; inputs are only sampled then.
    always_comb begin
        complete = 1'b1;
        if (state == BUSY) begin
            complete = (cnt == LAST_CNT);
        end else begin
            complete = !mem_req || (WAIT_CYCLES == 0);
        end
    end

    assign freeze = !complete && !rst;
    // Both enables high is a load; reset drops an in-flight store.
    assign mem_we = complete && MEM_w_en_in && !MEM_r_en_in && !addr_err && !rst;

    data_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_data_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (word_idx),
        .wdata(val_rm_in),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            WB_en_out    <= 1'b0;
            MEM_r_en_out <= 1'b0;
            dest_out     <= '0;
            alu_res_out  <= '0;
            mem_data_out <= '0;
            mem_err_out  <= 1'b0;
        end else if (!complete) begin
            state        <= BUSY;
            cnt          <= (state == BUSY) ? cnt + 4'd1 : 4'd0;
            WB_en_out    <= 1'b0;
            MEM_r_en_out <= 1'b0;
            mem_err_out  <= 1'b0;
        end else begin
            state        <= IDLE;
            cnt          <= 4'd0;
            WB_en_out    <= WB_en_in;
            MEM_r_en_out <= MEM_r_en_in;
            dest_out     <= dest_in;
            alu_res_out  <= alu_res_in;
            mem_err_out  <= addr_err;
            if (addr_err) begin
                mem_data_out <= '0;
            end else if (MEM_r_en_in) begin
                mem_data_out <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: one instance with 2 wait states, one with none.
module tb_mem_stage_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    typedef struct packed {
        logic        wb;
        logic        r;
        logic        w;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] val;
    } in_t;

    typedef struct {
        logic        wb;
        logic        r;
        logic        err;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] data;
    } exp_t;

    in_t in_a, in_b;

    logic        freeze_a, wb_a, r_a, err_a;
    logic [3:0]  dest_a;
    logic [31:0] alu_a, data_a;
    logic        freeze_b, wb_b, r_b, err_b;
    logic [3:0]  dest_b;
    logic [31:0] alu_b, data_b;

    mem_stage_unit #(
        .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .WB_en_in(in_a.wb), .MEM_r_en_in(in_a.r), .MEM_w_en_in(in_a.w),
        .dest_in(in_a.dest), .alu_res_in(in_a.alu), .val_rm_in(in_a.val),
        .freeze(freeze_a), .WB_en_out(wb_a), .MEM_r_en_out(r_a), .dest_out(dest_a),
        .alu_res_out(alu_a), .mem_data_out(data_a), .mem_err_out(err_a)
    );

    mem_stage_unit #(
        .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .WB_en_in(in_b.wb), .MEM_r_en_in(in_b.r), .MEM_w_en_in(in_b.w),
        .dest_in(in_b.dest), .alu_res_in(in_b.alu), .val_rm_in(in_b.val),
        .freeze(freeze_b), .WB_en_out(wb_b), .MEM_r_en_out(r_b), .dest_out(dest_b),
        .alu_res_out(alu_b), .mem_data_out(data_b), .mem_err_out(err_b)
    );

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] last_a, last_b;
    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit sel, input logic wb, input logic r, input logic w,
                          input logic [3:0] dest, input logic [31:0] addr,
                          input logic [31:0] val);
        exp_t        e;
        logic        req;
        logic        err;
        logic [31:0] off;
        int          idx;
        int          n_frz;
        int          exp_frz;
        req     = r | w;
        off     = addr - 32'd1024;
        idx     = int'(off[7:2]);
        err     = 1'b0;
`ifdef ADDR_CHECK_EN
        err     = req && ((addr < 32'd1024) || ((off >> 2) >= 32'd64) || (addr[1:0] != 2'b00));
`endif
        exp_frz = (req && !sel) ? 2 : 0;
        e.wb    = wb;
        e.r     = r;
        e.err   = err;
        e.dest  = dest;
        e.alu   = addr;
        if (sel) begin
            if (req && err) last_b = '0;
            else if (r) last_b = mem_b[idx];
            e.data = last_b;
            if (w && !r && !err) mem_b[idx] = val;
        end else begin
            if (req && err) last_a = '0;
            else if (r) last_a = mem_a[idx];
            e.data = last_a;
            if (w && !r && !err) mem_a[idx] = val;
        end
        sb_q.push_back(e);

        @(negedge clk);
        if (sel) in_b = '{wb, r, w, dest, addr, val};
        else     in_a = '{wb, r, w, dest, addr, val};
        #1;
        n_frz = 0;
        while ((sel ? freeze_b : freeze_a) && n_frz < 20) begin
            n_frz++;
            @(posedge clk);
            #1;
            check("bubble_wb", 32'(sel ? wb_b : wb_a), 32'd0);
            check("bubble_r", 32'(sel ? r_b : r_a), 32'd0);
            @(negedge clk);
            #1;
        end
        check("freeze_cycles", 32'(n_frz), 32'(exp_frz));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("wb_out", 32'(sel ? wb_b : wb_a), 32'(e.wb));
            check("r_out", 32'(sel ? r_b : r_a), 32'(e.r));
            check("dest_out", 32'(sel ? dest_b : dest_a), 32'(e.dest));
            check("alu_out", sel ? alu_b : alu_a, e.alu);
            check("data_out", sel ? data_b : data_a, e.data);
            check("err_out", 32'(sel ? err_b : err_a), 32'(e.err));
        end
    endtask

    initial begin
        in_a   = '0;
        in_b   = '0;
        rst    = 1'b1;
        last_a = '0;
        last_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_freeze_a", 32'(freeze_a), 32'd0);
        check("rst_wb_a", 32'(wb_a), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_data_a", data_a, 32'd0);
        check("rst_wb_b", 32'(wb_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h2A, 32'd0);
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1032, 32'hDEADBEEF);
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 32'd1032, 32'd0);
        run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd8, 32'd1032, 32'h0000FFFF);
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'd1032, 32'd0);
`ifdef ADDR_CHECK_EN
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1025, 32'h77);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'h10, 32'd0);
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 32'd1020, 32'd0);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 32'h20, 32'd0);
`else
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1280, 32'h11);
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'd1024, 32'd0);
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 32'd1026, 32'd0);
`endif

        // Reset in the second freeze cycle of a store must drop the write.
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1036, 32'h12345678);
        @(negedge clk);
        in_a = '{1'b0, 1'b0, 1'b1, 4'd1, 32'd1036, 32'h55};
        #1;
        check("mid_frz1", 32'(freeze_a), 32'd1);
        @(negedge clk);
        #1;
        check("mid_frz2", 32'(freeze_a), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_freeze", 32'(freeze_a), 32'd0);
        check("mid_wb", 32'(wb_a), 32'd0);
        check("mid_r", 32'(r_a), 32'd0);
        check("mid_dest", 32'(dest_a), 32'd0);
        check("mid_alu", alu_a, 32'd0);
        check("mid_data", data_a, 32'd0);
        check("mid_err", 32'(err_a), 32'd0);
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        rst  = 1'b0;
        in_a = '0;
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd10, 32'd1036, 32'd0);
        @(negedge clk);
        in_a = '0;

        run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1024, 32'hA1);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1028, 32'hB2);
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 32'd1024, 32'd0);
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 32'd1028, 32'd0);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h99, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
